// File: rtl/alu_pkg.sv
// Shared opcodes, compare selects, flag bit positions and FSM state encoding
// for the sequential ALU with iterative multiply/divide.
package alu_pkg;

  localparam logic [3:0] OP_MOVB   = 4'h0;
  localparam logic [3:0] OP_ADDSUB = 4'h1;
  localparam logic [3:0] OP_MULT   = 4'h2;
  localparam logic [3:0] OP_DIV    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_NOR    = 4'h6;
  localparam logic [3:0] OP_SRL    = 4'h7;
  localparam logic [3:0] OP_SLL    = 4'h8;
  localparam logic [3:0] OP_SRA    = 4'h9;
  localparam logic [3:0] OP_LUI    = 4'hA;
  localparam logic [3:0] OP_ADD4   = 4'hB;
  localparam logic [3:0] OP_XOR    = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_MTHI   = 4'hE;
  localparam logic [3:0] OP_MTLO   = 4'hF;

  localparam logic [3:0] CMP_EQ  = 4'd0;
  localparam logic [3:0] CMP_NE  = 4'd1;
  localparam logic [3:0] CMP_LT  = 4'd2;
  localparam logic [3:0] CMP_LTU = 4'd3;
  localparam logic [3:0] CMP_LE  = 4'd4;
  localparam logic [3:0] CMP_GT  = 4'd5;
  localparam logic [3:0] CMP_GE  = 4'd6;
  localparam logic [3:0] CMP_GEU = 4'd7;

  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply (shift-add) / divide (restoring) engine on operand
// magnitudes, with the sign fixup applied combinationally on the final state.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d, quo_q, quo_d, opd_q;
  logic               is_div_q, signed_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               neg_qp, neg_r;

  assign mag_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: quo_q holds the multiplier and collects the low product bits.
  // Divide: quo_q holds the dividend and collects the quotient bits.
  assign add_sum   = {1'b0, acc_q} + ({(WIDTH+1){quo_q[0]}} & {1'b0, opd_q});
  assign div_shift = {acc_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_ge    = div_shift >= {1'b0, opd_q};

  always_comb begin
    acc_d = acc_q;
    quo_d = quo_q;
    if (is_div_q) begin
      acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = add_sum[WIDTH:1];
      quo_d = {add_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      acc_q    <= '0;
      quo_q    <= is_div_i ? mag_a : mag_b;
      opd_q    <= is_div_i ? mag_b : mag_a;
      is_div_q <= is_div_i;
      signed_q <= signed_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = step_i && (cnt_q == SHAMT_W'(WIDTH - 1));

  assign neg_qp   = signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_r    = signed_q && a_q[WIDTH-1];
  assign prod     = {acc_q, quo_q};
  assign prod_fix = neg_qp ? -prod : prod;
  assign dbz_o    = is_div_q && (b_q == '0);

  always_comb begin
    hi_o = prod_fix[2*WIDTH-1:WIDTH];
    lo_o = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      hi_o = neg_r ? -acc_q : acc_q;
      lo_o = neg_qp ? -quo_q : quo_q;
      if (dbz_o) begin
        hi_o = a_q;
        lo_o = '1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_md.sv
// EX-stage ALU: single-cycle ops resolve in one clock; MULT/DIV run on the
// iterative engine and own HI/LO. All architectural outputs are registered.
module alu_seq_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [1:0]       sign,
  input  logic [3:0]       cmpsignal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic [3:0]       carryFlag,
  output logic             div_by_zero,
  output alu_state_e       dbg_state
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Handshake: start is taken only in IDLE (busy=0); the op's results are
  // visible with done, a 1-cycle pulse, and a start during done is accepted.
  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic             is_md, md_load, md_last, md_dbz;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0] b_eff, as_res;
  logic [WIDTH:0]   as_sum;
  logic [3:0]       as_flags, cmp_flags;
  logic             eq, lt_s, lt_u, cmp_cond, as_ovf;

  assign is_md   = (operation == OP_MULT) || (operation == OP_DIV);
  assign md_load = start && (state_q == ST_IDLE) && is_md;
  assign sh      = A[SHAMT_W-1:0];

  // sign[0] selects subtract; the carry-out of A + ~B + 1 is the inverted borrow.
  assign b_eff  = sign[0] ? ~B : B;
  assign as_sum = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sign[0]};
  assign as_res = as_sum[WIDTH-1:0];
  assign as_ovf = sign[0] ? ((A[WIDTH-1] ^ B[WIDTH-1]) & (as_res[WIDTH-1] ^ A[WIDTH-1]))
                          : (~(A[WIDTH-1] ^ B[WIDTH-1]) & (as_res[WIDTH-1] ^ A[WIDTH-1]));

  assign eq   = (A == B);
  assign lt_s = $signed(A) < $signed(B);
  assign lt_u = A < B;

  always_comb begin
    as_flags         = '0;
    as_flags[FLAG_V] = sign[1] & as_ovf;
    as_flags[FLAG_N] = as_res[WIDTH-1];
    as_flags[FLAG_Z] = (as_res == '0);
    as_flags[FLAG_C] = sign[0] ? ~as_sum[WIDTH] : as_sum[WIDTH];
    cmp_flags         = '0;
    cmp_flags[FLAG_Z] = eq;
    cmp_flags[FLAG_N] = lt_s;
    cmp_flags[FLAG_C] = lt_u;
  end

  always_comb begin
    cmp_cond = 1'b0;
    case (cmpsignal)
      CMP_EQ:  cmp_cond = eq;
      CMP_NE:  cmp_cond = !eq;
      CMP_LT:  cmp_cond = lt_s;
      CMP_LTU: cmp_cond = lt_u;
      CMP_LE:  cmp_cond = lt_s || eq;
      CMP_GT:  cmp_cond = !(lt_s || eq);
      CMP_GE:  cmp_cond = !lt_s;
      CMP_GEU: cmp_cond = !lt_u;
      default: cmp_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flags_d = flags_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = !is_md;
          case (operation)
            OP_MOVB:   y_d = B;
            OP_ADDSUB: begin
              y_d     = as_res;
              flags_d = as_flags;
            end
            OP_MULT:   state_d = ST_ITER;
            OP_DIV: begin
              state_d = ST_ITER;
              dbz_d   = 1'b0;
            end
            OP_AND:    y_d = A & B;
            OP_OR:     y_d = A | B;
            OP_NOR:    y_d = ~(A | B);
            OP_XOR:    y_d = A ^ B;
            OP_SRL:    y_d = B >> sh;
            OP_SLL:    y_d = B << sh;
            OP_SRA:    y_d = $signed(B) >>> sh;
            OP_LUI:    y_d = {A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD4:   y_d = B + WIDTH'(4);
            OP_CMP: begin
              y_d     = {{(WIDTH-1){1'b0}}, cmp_cond};
              flags_d = cmp_flags;
            end
            OP_MTHI:   hi_d = A;
            OP_MTLO:   lo_d = A;
            default:   y_d = y_q;
          endcase
        end
      end
      ST_ITER: if (md_last) state_d = ST_FIX;
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        hi_d    = md_hi;
        lo_d    = md_lo;
        dbz_d   = dbz_q | md_dbz;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .reset    (reset),
    .load_i   (md_load),
    .step_i   (state_q == ST_ITER),
    .is_div_i (operation == OP_DIV),
    .signed_i (sign[1]),
    .a_i      (A),
    .b_i      (B),
    .last_o   (md_last),
    .hi_o     (md_hi),
    .lo_o     (md_lo),
    .dbz_o    (md_dbz)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign Y           = y_q;
  assign outHI       = hi_q;
  assign outLO       = lo_q;
  assign carryFlag   = flags_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_seq_md.sv
// Directed bench for alu_seq_md: 32-bit instance with full result scoreboard
// and latency tracking, plus a 16-bit instance for width-dependent ops.
module tb_alu_seq_md;
  import alu_pkg::*;

  localparam int L1  = 1;
  localparam int LMD = 34;

  typedef struct {
    int          cyc;
    logic [31:0] y, hi, lo;
    logic [3:0]  fl;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst, start;
  logic [3:0] op, cmp;
  logic [1:0] sgn;
  logic [31:0] a, b, y, hi, lo;
  logic busy, done, dbz;
  logic [3:0] fl;
  alu_state_e st;

  logic rst16, start16;
  logic [3:0] op16, cmp16;
  logic [1:0] sgn16;
  logic [15:0] a16, b16, y16, hi16, lo16;
  logic busy16, done16, dbz16;
  logic [3:0] fl16;
  alu_state_e st16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc;
  exp_t exp_q[$];
  logic [15:0] exp16_q[$];
  exp_t mon_e;
  logic [31:0] m_y, m_hi, m_lo;
  logic [3:0]  m_fl;
  logic        m_dbz;

  alu_seq_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst), .start(start), .operation(op), .sign(sgn),
    .cmpsignal(cmp), .A(a), .B(b), .busy(busy), .done(done), .Y(y),
    .outHI(hi), .outLO(lo), .carryFlag(fl), .div_by_zero(dbz), .dbg_state(st)
  );

  alu_seq_md #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst16), .start(start16), .operation(op16), .sign(sgn16),
    .cmpsignal(cmp16), .A(a16), .B(b16), .busy(busy16), .done(done16), .Y(y16),
    .outHI(hi16), .outLO(lo16), .carryFlag(fl16), .div_by_zero(dbz16), .dbg_state(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [1:0] s, input logic [3:0] c,
                       input logic [31:0] aa, input logic [31:0] bb, input int lat);
    exp_t e;
    op = o; sgn = s; cmp = c; a = aa; b = bb; start = 1'b1;
    issue_cyc = cyc;
    e.cyc = cyc + lat;
    e.y = m_y; e.hi = m_hi; e.lo = m_lo; e.fl = m_fl; e.dbz = m_dbz;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [3:0] c,
                         input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] yexp);
    op16 = o; cmp16 = c; a16 = aa; b16 = bb; start16 = 1'b1;
    exp16_q.push_back(yexp);
    @(posedge clk);
    #1 start16 = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("Y", y, mon_e.y);
        chk("HI", hi, mon_e.hi);
        chk("LO", lo, mon_e.lo);
        chk("flags", fl, mon_e.fl);
        chk("div_by_zero", dbz, mon_e.dbz);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst16 && done16) begin
      if (exp16_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        chk("Y16", y16, exp16_q.pop_front());
      end
    end
  end

  initial begin
    int c0, bw_bad;
    rst = 1'b1; start = 1'b0; op = '0; sgn = '0; cmp = '0; a = '0; b = '0;
    rst16 = 1'b1; start16 = 1'b0; op16 = '0; sgn16 = 2'b00; cmp16 = '0; a16 = '0; b16 = '0;
    m_y = '0; m_hi = '0; m_lo = '0; m_fl = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst16 = 1'b0;

    chk("rst_Y", y, 0);
    chk("rst_HI", hi, 0);
    chk("rst_LO", lo, 0);
    chk("rst_ctrl", {busy, done, dbz, fl}, 0);
    chk("rst_state", st, ST_IDLE);
    chk("rst16_all", {busy16, done16, dbz16, fl16, hi16, lo16, y16}, 0);
    chk("rst16_state", st16, ST_IDLE);

    // single-cycle ops, issued back to back
    m_y = 32'h80000000; m_fl = 4'b0011;
    issue(OP_ADDSUB, 2'b10, CMP_EQ, 32'h7FFFFFFF, 32'h00000001, L1);
    m_y = 32'hFFFFFFFE; m_fl = 4'b1010;
    issue(OP_ADDSUB, 2'b01, CMP_EQ, 32'd3, 32'd5, L1);
    m_y = 32'hF000F000;
    issue(OP_AND, 2'b00, CMP_EQ, 32'hF0F0F0F0, 32'hFF00FF00, L1);
    m_y = 32'h0F0F00F0;
    issue(OP_OR, 2'b00, CMP_EQ, 32'h0F0F0000, 32'h000000F0, L1);
    m_y = 32'h0FF00FF0;
    issue(OP_XOR, 2'b00, CMP_EQ, 32'hF0F0F0F0, 32'hFF00FF00, L1);
    m_y = 32'h0000FFFF;
    issue(OP_NOR, 2'b00, CMP_EQ, 32'h00000000, 32'hFFFF0000, L1);
    m_y = 32'h00000010;
    issue(OP_SLL, 2'b00, CMP_EQ, 32'd4, 32'd1, L1);
    m_y = 32'h00800000;
    issue(OP_SRL, 2'b00, CMP_EQ, 32'h00000028, 32'h80000000, L1);
    m_y = 32'hF8000000;
    issue(OP_SRA, 2'b00, CMP_EQ, 32'd4, 32'h80000000, L1);
    m_y = 32'hABCD0000;
    issue(OP_LUI, 2'b00, CMP_EQ, 32'h1234ABCD, 32'h0, L1);
    m_y = 32'h00000002;
    issue(OP_ADD4, 2'b00, CMP_EQ, 32'h0, 32'hFFFFFFFE, L1);
    m_y = 32'd1; m_fl = 4'b0010;
    issue(OP_CMP, 2'b00, CMP_LT, 32'hFFFFFFFF, 32'd1, L1);
    m_y = 32'd0;
    issue(OP_CMP, 2'b00, CMP_LTU, 32'hFFFFFFFF, 32'd1, L1);
    m_y = 32'd1; m_fl = 4'b0000;
    issue(OP_CMP, 2'b00, CMP_GT, 32'd5, 32'd3, L1);
    m_y = 32'd1; m_fl = 4'b0100;
    issue(OP_CMP, 2'b00, CMP_EQ, 32'd5, 32'd5, L1);
    issue(OP_CMP, 2'b00, CMP_GEU, 32'd5, 32'd5, L1);
    m_y = 32'd0;
    issue(OP_CMP, 2'b00, 4'd8, 32'd5, 32'd5, L1);
    m_y = 32'hDEADBEEF;
    issue(OP_MOVB, 2'b00, CMP_EQ, 32'h0, 32'hDEADBEEF, L1);
    m_hi = 32'h11111111;
    issue(OP_MTHI, 2'b00, CMP_EQ, 32'h11111111, 32'h0, L1);
    m_lo = 32'h22222222;
    issue(OP_MTLO, 2'b00, CMP_EQ, 32'h22222222, 32'h0, L1);

    // signed MULT with busy window and a stray start while busy
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
    issue(OP_MULT, 2'b10, CMP_EQ, 32'hFFFFFFFD, 32'd7, LMD);
    c0 = issue_cyc;
    bw_bad = 0;
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      if (busy !== 1'b1) bw_bad++;
      if (j == 5) begin op = OP_ADDSUB; sgn = 2'b10; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (j == 6) start = 1'b0;
    end
    chk("busy_window_bad_cycles", bw_bad, 0);
    wait_until(c0 + 34);
    chk("busy_in_done_cycle", busy, 0);

    // DIV accepted in the MULT done cycle
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
    issue(OP_DIV, 2'b10, CMP_EQ, 32'hFFFFFFF9, 32'd2, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 34);
    m_hi = 32'd5; m_lo = 32'hFFFFFFFF; m_dbz = 1'b1;
    issue(OP_DIV, 2'b00, CMP_EQ, 32'd5, 32'd0, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 34);
    m_y = 32'd2; m_fl = 4'b0000;
    issue(OP_ADDSUB, 2'b00, CMP_EQ, 32'd1, 32'd1, L1);
    m_hi = 32'd0; m_lo = 32'd42;
    issue(OP_MULT, 2'b00, CMP_EQ, 32'd6, 32'd7, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 34);
    m_hi = 32'd0; m_lo = 32'h80000000; m_dbz = 1'b0;
    issue(OP_DIV, 2'b10, CMP_EQ, 32'h80000000, 32'hFFFFFFFF, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 34);
    m_hi = 32'd2; m_lo = 32'd14;
    issue(OP_DIV, 2'b00, CMP_EQ, 32'd100, 32'd7, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 34);

    // reset during ITER count 10 aborts the op
    issue(OP_MULT, 2'b00, CMP_EQ, 32'h12345678, 32'd9, LMD);
    c0 = issue_cyc;
    wait_until(c0 + 11);
    chk("iter_state_before_abort", st, ST_ITER);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_HI", hi, 0);
    chk("abort_LO", lo, 0);
    chk("abort_Y_flags", {y, fl}, 0);
    m_y = '0; m_hi = '0; m_lo = '0; m_fl = '0; m_dbz = 1'b0;
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
    issue(OP_MULT, 2'b00, CMP_EQ, 32'hFFFFFFFF, 32'hFFFFFFFF, LMD);

    // 16-bit instance
    issue16(OP_SRA, CMP_EQ, 16'h0013, 16'h8000, 16'hF000);
    issue16(OP_SRL, CMP_EQ, 16'h0013, 16'h8000, 16'h1000);
    issue16(OP_LUI, CMP_EQ, 16'h00AB, 16'h0000, 16'hAB00);
    issue16(OP_CMP, CMP_LTU, 16'h0001, 16'hFFFF, 16'h0001);

    for (int i = 0; i < 200 && (exp_q.size() > 0 || exp16_q.size() > 0); i++) @(posedge clk);
    checks++;
    if (exp_q.size() > 0 || exp16_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_q.size(), exp16_q.size());
    end
    repeat (3) @(posedge clk);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
